// File: rtl/clock_pkg.sv
// Shared types and constants for the keypad scanner. The scanner feeds the
// time-set/alarm control logic that lives alongside the clock counters.
package clock_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  // Row lines are pulled up, so "no key on this column" reads as all ones.
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  localparam int CODE_W = 4;
  localparam int IDX_W  = 2;

  // Index of the lowest-numbered active-low row; callers only use it when at
  // least one row is low, so the all-high case simply falls through to 3.
  function automatic logic [IDX_W-1:0] lowest_low(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  // Active-low one-hot column strobe for a column index.
  function automatic logic [3:0] col_strobe(input logic [IDX_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous key matrix row lines.
module row_sync
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raw,
  output logic [3:0] synced
);

  logic [3:0] meta;

  // Two-stage capture; reset to the released (all high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= ROW_IDLE;
      synced <= ROW_IDLE;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 key matrix scanner: strobes columns (active-low), synchronises and
// debounces the row returned for the first key found, and reports one code
// per accepted press.
//
// Output handshake: key_valid is a one-cycle pulse with no back-pressure;
// key_code is updated on the same edge and then holds until the next pulse.
// key_held rises with key_valid and falls once the release is debounced.
// The FSM state is kept in the signal `state` (type scan_state_e).
module key_matrix_scan
  import clock_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_row,
  output logic [3:0]        key_col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

  scan_state_e       state;
  logic [SLOT_W-1:0] slot_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [IDX_W-1:0]  col_idx;
  logic [IDX_W-1:0]  row_idx;
  logic [IDX_W-1:0]  col_nxt;
  logic [3:0]        rs;

  row_sync u_row_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (key_row),
    .synced (rs)
  );

  // Next column wraps 3 -> 0 by natural 2-bit overflow.
  assign col_nxt = col_idx + 2'd1;

  // Scan slot timing, debounce counting and key reporting FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      deb_cnt   <= '0;
      col_idx   <= '0;
      row_idx   <= '0;
      key_col   <= 4'b1110;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            if (rs != ROW_IDLE) begin
              // Something is down on this column: freeze it and debounce.
              row_idx <= lowest_low(rs);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_nxt;
              key_col <= col_strobe(col_nxt);
            end
          end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!rs[row_idx]) begin
            if (deb_cnt == DEB_LAST) begin
              key_valid <= 1'b1;
              key_code  <= {row_idx, col_idx};
              key_held  <= 1'b1;
              state     <= PRESSED;
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            // Bounce: drop it and carry on scanning from the next column.
            state    <= IDLE;
            slot_cnt <= '0;
            col_idx  <= col_nxt;
            key_col  <= col_strobe(col_nxt);
          end
        end
        PRESSED: begin
          // Only the accepted row is watched; other keys are ignored.
          if (rs[row_idx]) begin
            deb_cnt <= '0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (rs[row_idx]) begin
            if (deb_cnt == DEB_LAST) begin
              key_held <= 1'b0;
              state    <= IDLE;
              slot_cnt <= '0;
              col_idx  <= col_nxt;
              key_col  <= col_strobe(col_nxt);
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            // Release bounce: the key is still considered held.
            deb_cnt <= '0;
            state   <= PRESSED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan with SCAN_DIV=4, DEBOUNCE_CNT=8 and a behavioural
// 4x4 switch matrix. Expected key reports go into a queue when a press is
// issued; a monitor pops and compares on every key_valid pulse.
module tb_key_matrix_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  // Column reaches the key, one full slot passes before the slot-end sample,
  // then DEBOUNCE_CNT stable samples.
  localparam int PRESS_LAT    = SCAN_DIV + DEBOUNCE_CNT;
  // Two synchroniser stages, one cycle to notice the release, then debounce.
  localparam int RELEASE_LAT  = 2 + 1 + DEBOUNCE_CNT;
  localparam int HOLD_SHORT_MAX = 6;
  localparam int HOLD_LONG_MIN  = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0] pressed [4];   // pressed[row][col]
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];
  int         exp_t_q[$];
  logic [3:0] last_code = 4'd0;
  logic       prev_valid = 1'b0;

  key_matrix_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Switch matrix: a row is pulled low by any pressed key on a strobed column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      key_row[r] = 1'b1;
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !key_col[c]) key_row[r] = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [3:0] strobe(input int c);
    logic [3:0] v;
    v = 4'b1111;
    v[c[1:0]] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] code_of(input int r, input int c);
    return 4'(r * 4 + c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
      check("held_with_valid", {31'd0, key_held}, 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got pulse with code %0h, expected no pulse (cycle %0d)",
                 key_code, cyc);
      end else begin
        check("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
        check("valid_cycle", cyc, exp_t_q.pop_front());
      end
    end
    prev_valid = key_valid;
  end

  // ---------------- driver tasks ----------------
  // Called at the negedge right after rst is released: columns step once per
  // SCAN_DIV cycles starting from column 0, with no reports.
  task automatic check_scan();
    for (int k = 1; k <= 4 * SCAN_DIV + 2; k++) begin
      @(negedge clk);
      check("scan_col", {28'd0, key_col}, {28'd0, strobe((k / SCAN_DIV) % 4)});
      check("scan_no_valid", {31'd0, key_valid}, 32'd0);
    end
  endtask

  task automatic wait_not_col(input int c);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (key_col != strobe(c)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("wait_leave_col", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_col(input int c, output int t0);
    bit ok = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_col == strobe(c)) begin ok = 1'b1; t0 = cyc; break; end
    end
    check("wait_reach_col", {31'd0, ok}, 32'd1);
  endtask

  // Press (r,c) before its column is strobed, then keep it down for `hold`
  // cycles counted from the cycle the column is first strobed.
  task automatic press_key(input int r, input int c, input int hold);
    int  t0;
    bit  is_long;
    is_long = (hold >= HOLD_LONG_MIN);
    wait_not_col(c);
    pressed[r][c] = 1'b1;
    wait_col(c, t0);
    if (is_long) begin
      exp_q.push_back(code_of(r, c));
      exp_t_q.push_back(t0 + PRESS_LAT);
      last_code = code_of(r, c);
    end
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (is_long) begin
        check("col_frozen", {28'd0, key_col}, {28'd0, strobe(c)});
        check("held_during_press", {31'd0, key_held}, {31'd0, (i >= PRESS_LAT)});
      end
    end
  endtask

  // Let go of (r,c) and check the scanner returns to scanning at column c+1.
  task automatic release_key(input int r, input int c, input bit was_long);
    bit ok = 1'b0;
    int lat = 0;
    pressed[r][c] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (was_long ? (key_held == 1'b0) : (key_col != strobe(c))) begin
        ok  = 1'b1;
        lat = k;
        break;
      end
    end
    check(was_long ? "release_seen" : "scan_resume_seen", {31'd0, ok}, 32'd1);
    if (was_long) check("release_latency", lat, RELEASE_LAT);
    check("resume_col", {28'd0, key_col}, {28'd0, strobe((c + 1) % 4)});
    check("code_kept", {28'd0, key_code}, {28'd0, last_code});
    check("held_after", {31'd0, key_held}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_drop;
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;

    // 1. reset and free scan
    rst = 1'b1;
    tick(3);
    check("rst_key_col", {28'd0, key_col}, 32'h0000000e);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_held", {31'd0, key_held}, 32'd0);
    rst = 1'b0;
    check_scan();

    // 2. clean press of (2,1)
    press_key(2, 1, 20);
    release_key(2, 1, 1'b1);
    tick(3);

    // 3. press bounce on (2,1): too short to be accepted
    press_key(2, 1, 5);
    release_key(2, 1, 1'b0);
    tick(3);

    // 4. release bounce on a held (2,1)
    press_key(2, 1, HOLD_LONG_MIN);
    pressed[2][1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held_through_bounce", {31'd0, key_held}, 32'd1);
    end
    pressed[2][1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("held_after_repress", {31'd0, key_held}, 32'd1);
      check("col_frozen_repress", {28'd0, key_col}, {28'd0, strobe(1)});
    end
    release_key(2, 1, 1'b1);
    tick(3);

    // 5. two keys: (0,3) first, (1,0) pressed meanwhile and reported later
    press_key(0, 3, HOLD_LONG_MIN);
    pressed[1][0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("first_key_wins_col", {28'd0, key_col}, {28'd0, strobe(3)});
      check("first_key_wins_held", {31'd0, key_held}, 32'd1);
    end
    pressed[0][3] = 1'b0;
    t_drop = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (key_held == 1'b0) begin t_drop = k; break; end
    end
    check("two_key_release_latency", t_drop, RELEASE_LAT);
    check("two_key_resume_col", {28'd0, key_col}, {28'd0, strobe(0)});
    exp_q.push_back(code_of(1, 0));
    exp_t_q.push_back(cyc + PRESS_LAT);
    last_code = code_of(1, 0);
    for (int i = 1; i <= HOLD_LONG_MIN; i++) begin
      @(negedge clk);
      check("second_key_held", {31'd0, key_held}, {31'd0, (i >= PRESS_LAT)});
    end
    release_key(1, 0, 1'b1);
    tick(2);

    // randomized presses, short ones must be rejected and long ones reported
    for (int n = 0; n < 12; n++) begin
      int r, c, hold;
      bit lng;
      r    = $urandom_range(0, 3);
      c    = $urandom_range(0, 3);
      lng  = 1'($urandom_range(0, 1));
      hold = lng ? $urandom_range(HOLD_LONG_MIN, 30) : $urandom_range(1, HOLD_SHORT_MAX);
      press_key(r, c, hold);
      release_key(r, c, lng);
      tick($urandom_range(0, 5));
    end

    // 6. reset in the middle of a debounce
    begin
      int t0;
      wait_not_col(2);
      pressed[3][2] = 1'b1;
      wait_col(2, t0);
      tick(SCAN_DIV + 4);
      rst = 1'b1;
      tick(1);
      check("midrst_key_col", {28'd0, key_col}, 32'h0000000e);
      check("midrst_key_held", {31'd0, key_held}, 32'd0);
      check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
      check("midrst_key_code", {28'd0, key_code}, 32'd0);
      pressed[3][2] = 1'b0;
      last_code = 4'd0;
      tick(3);
      rst = 1'b0;
      check_scan();
    end

    tick(20);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
